loop_ctrl: RTL and testbench
============================

LOOP_CTRL -- requirements
Module: loop_ctrl

Interface
REQ-001 Clk  input  1  system clock; all state changes on rising edge.
REQ-002 RST  input  1  reset, synchronous, active-high.
REQ-003 start  input  1  request to begin a loop; sampled in IDLE only.
REQ-004 start_val  input  4  initial count loaded into the loop counter register.
REQ-005 f_z  input  1  counter compare flag; 1 = limit > count (continue), 0 = stop.
REQ-006 body_done  input  1  loop body finished; sampled in WAIT only.
REQ-007 abort  input  1  terminate the loop early; sampled in any non-IDLE state.
REQ-008 f_wen  output  1  load strobe to counter register.
REQ-009 f_rst  output  1  clear strobe to counter register.
REQ-010 f_inc  output  1  increment strobe to counter register.
REQ-011 f_bus  output  4  load data to counter register; equals latched start_val while f_wen=1, else 0.
REQ-012 body_go  output  1  one-cycle pulse launching one loop-body iteration.
REQ-013 busy  output  1  1 in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse on loop termination.
REQ-015 iter_cnt  output  4  completed iterations of the current or last loop; wraps 15->0.
REQ-016 aborted  output  1  last loop ended by abort; held until next start.
REQ-017 timeout  output  1  last loop ended by body watchdog; held until next start.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD, SETTLE, CHECK, BODY, WAIT, STEP and FIN; all outputs SHALL be Moore, registered from the state.
REQ-019 In IDLE with start=1, the block SHALL latch start_val, clear iter_cnt, aborted and timeout, and go to LOAD.
REQ-020 In LOAD, the block SHALL assert f_rst=1 if the latched value is 0, else assert f_wen=1 with f_bus equal to the latched value, for exactly 1 cycle, and then go to SETTLE.
REQ-021 SETTLE SHALL last exactly 1 cycle so that f_z reflects the updated count, and then go to CHECK.
REQ-022 In CHECK, the block SHALL go to BODY if f_z=1, else go to FIN.
REQ-023 In BODY, the block SHALL assert body_go for 1 cycle, clear the watchdog counter, and then go to WAIT.
REQ-024 In WAIT, body_done=1 SHALL move the FSM to STEP; otherwise the 8-bit watchdog increments each cycle.
REQ-025 A watchdog value of 255 in WAIT SHALL set timeout=1 and move the FSM to FIN.
REQ-026 In STEP, the block SHALL assert f_inc for 1 cycle, increment iter_cnt modulo 16, and then go to SETTLE.
REQ-027 In FIN, the block SHALL assert done for 1 cycle and then go to IDLE.
REQ-028 abort=1 in LOAD, SETTLE, CHECK, BODY, WAIT or STEP SHALL set aborted=1 and move the FSM to FIN on the next edge; no strobe is issued in that cycle's successor.
REQ-029 abort and body_done both at 1 in WAIT: abort SHALL win, with no STEP, no f_inc and iter_cnt unchanged.
REQ-030 abort and watchdog expiry in the same cycle: abort SHALL win, with aborted=1 and timeout=0.
REQ-031 start while busy=1, body_done outside WAIT, and abort in IDLE or FIN SHALL be ignored.
REQ-032 At most one of f_wen, f_rst and f_inc SHALL be 1 in any cycle.
REQ-033 A zero-iteration loop (f_z=0 at first CHECK) SHALL give done 4 cycles after start is sampled, with iter_cnt=0.

Reset
REQ-034 RST=1 at a clock edge SHALL force IDLE and the following values on all outputs:
- f_wen, f_rst, f_inc, body_go, busy and done = 0;
- f_bus = 0;
- iter_cnt = 0;
- aborted and timeout = 0;
- watchdog counter and latched start_val = 0.
REQ-035 RST SHALL take priority over start, abort and body_done, in every state including mid-WAIT.
REQ-036 The block SHALL issue no done pulse for a loop killed by RST.

Verification
REQ-037 Counter model with limit=3, start_val=0, body_done returned 2 cycles after each body_go -> f_rst once, 3 body_go pulses, 3 f_inc pulses, done pulse, iter_cnt=3, aborted=0, timeout=0.
REQ-038 Limit=5, start_val=5 -> f_wen with f_bus=5, zero body_go, done exactly 4 cycles after start, iter_cnt=0.
REQ-039 Limit=4, start_val=0, abort=1 during WAIT of the 2nd iteration together with body_done=1 -> no further f_inc, done next cycle+1, aborted=1, iter_cnt=1.
REQ-040 Limit=2, body_done never asserted -> timeout=1 after 255 WAIT cycles, done pulse, iter_cnt=0, no f_inc.
REQ-041 RST=1 in WAIT of iteration 1, then start=1 with start_val=1 and limit=3 -> all outputs 0 during reset, no done for the killed loop; new loop gives 2 iterations, iter_cnt=2.
REQ-042 start pulsed again during BODY and STEP of a running loop -> ignored; iteration count and strobe sequence identical to REQ-037.

Source files
------------

// File: rtl/loop_ctrl.sv
// Loop sequencer: loads an external counter register, runs the loop body until the
// counter's compare flag drops, and handles abort and a body watchdog.
module loop_ctrl (
    input  logic       Clk,
    input  logic       RST,
    input  logic       start,
    input  logic [3:0] start_val,
    input  logic       f_z,
    input  logic       body_done,
    input  logic       abort,
    output logic       f_wen,
    output logic       f_rst,
    output logic       f_inc,
    output logic [3:0] f_bus,
    output logic       body_go,
    output logic       busy,
    output logic       done,
    output logic [3:0] iter_cnt,
    output logic       aborted,
    output logic       timeout
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] CHECK  = 3'd3;
    localparam logic [2:0] BODY   = 3'd4;
    localparam logic [2:0] WAIT   = 3'd5;
    localparam logic [2:0] STEP   = 3'd6;
    localparam logic [2:0] FIN    = 3'd7;

    localparam logic [7:0] WD_LIMIT = 8'hFF;

    logic [2:0] state;
    logic [2:0] state_nx;
    logic [7:0] wd;
    logic [3:0] sv_q;
    logic       kill;
    logic       wd_expire;

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        kill      = abort && (state != IDLE) && (state != FIN);
        wd_expire = (state == WAIT) && !body_done && (wd == WD_LIMIT);
        state_nx  = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = SETTLE;
            SETTLE:  state_nx = CHECK;
            CHECK:   state_nx = f_z ? BODY : FIN;
            BODY:    state_nx = WAIT;
            WAIT: begin
                if (body_done)      state_nx = STEP;
                else if (wd_expire) state_nx = FIN;
            end
            STEP:    state_nx = SETTLE;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (kill) state_nx = FIN;
    end

    // Outputs are registered decodes of the current state, so they trail it by one
    // cycle; an abort in the same cycle suppresses the strobe that state would emit.
    always_ff @(posedge Clk) begin
        if (RST) begin
            state    <= IDLE;
            wd       <= '0;
            sv_q     <= '0;
            iter_cnt <= '0;
            aborted  <= 1'b0;
            timeout  <= 1'b0;
            f_wen    <= 1'b0;
            f_rst    <= 1'b0;
            f_inc    <= 1'b0;
            f_bus    <= '0;
            body_go  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= state_nx;

            if (state == IDLE && start) begin
                sv_q     <= start_val;
                iter_cnt <= '0;
                aborted  <= 1'b0;
                timeout  <= 1'b0;
            end

            if (kill) begin
                aborted <= 1'b1;
            end else begin
                if (state == BODY)
                    wd <= '0;
                else if (state == WAIT && !body_done && wd != WD_LIMIT)
                    wd <= wd + 8'd1;
                if (wd_expire)
                    timeout <= 1'b1;
                if (state == STEP)
                    iter_cnt <= iter_cnt + 4'd1;
            end

            f_wen   <= (state == LOAD) && !kill && (sv_q != 4'd0);
            f_rst   <= (state == LOAD) && !kill && (sv_q == 4'd0);
            f_bus   <= ((state == LOAD) && !kill) ? sv_q : 4'd0;
            f_inc   <= (state == STEP) && !kill;
            body_go <= (state == BODY) && !kill;
            busy    <= (state != IDLE);
            done    <= (state == FIN);
        end
    end

endmodule

// File: tb/tb_loop_ctrl.sv
// Bench for loop_ctrl: a behavioural counter register and body responder around the
// DUT, a table of loop scenarios, and hand sequences for reset and idle corner cases.
module tb_loop_ctrl;

    logic       Clk = 1'b0;
    logic       RST;
    logic       start;
    logic [3:0] start_val;
    logic       f_z;
    logic       body_done = 1'b0;
    logic       abort;
    logic       f_wen, f_rst, f_inc;
    logic [3:0] f_bus;
    logic       body_go, busy, done;
    logic [3:0] iter_cnt;
    logic       aborted, timeout;

    logic [4:0] cnt_m = 5'd0;
    logic [4:0] limit = 5'd0;
    logic       resp_en = 1'b0;
    logic       dly = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    loop_ctrl dut (
        .Clk(Clk), .RST(RST), .start(start), .start_val(start_val), .f_z(f_z),
        .body_done(body_done), .abort(abort), .f_wen(f_wen), .f_rst(f_rst),
        .f_inc(f_inc), .f_bus(f_bus), .body_go(body_go), .busy(busy), .done(done),
        .iter_cnt(iter_cnt), .aborted(aborted), .timeout(timeout)
    );

    always #5 Clk = ~Clk;

    // Counter register: 5 bits wide so a limit of 16 can exercise iter_cnt wrap.
    always @(posedge Clk) begin
        if (f_rst)      cnt_m <= 5'd0;
        else if (f_wen) cnt_m <= {1'b0, f_bus};
        else if (f_inc) cnt_m <= cnt_m + 5'd1;
    end
    assign f_z = (limit > cnt_m);

    // Body responder: body_done pulses two cycles after each body_go.
    always @(posedge Clk) begin
        dly       <= resp_en && body_go;
        body_done <= resp_en && dly;
    end

    typedef struct {
        string      name;
        logic [4:0] limit;
        logic [3:0] sv;
        logic       resp;
        int         mode;     // 0 none, 1 abort with body_done of iteration abort_at, 2 abort at watchdog expiry
        int         abort_at;
        logic       spam;
        int         go, inc, rst, wen, bus, iter;
        logic       ab, to;
        int         lat;      // negedges from trigger to done, -1 to skip
    } scen_t;

    scen_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int all_outs();
        return int'({f_wen, f_rst, f_inc, f_bus, body_go, busy, done, iter_cnt, aborted, timeout});
    endfunction

    task automatic run_scen(input scen_t s);
        int   cyc = 0, done_at = -1, trig = 0, wd_cd = 0, last_bus = 0;
        int   n_go = 0, n_inc = 0, n_rst = 0, n_wen = 0, n_done = 0, n_viol = 0;
        logic fired = 1'b0;
        limit     = s.limit;
        resp_en   = s.resp;
        start_val = s.sv;
        start     = 1'b1;
        while (cyc < 2000 && !(done_at >= 0 && cyc >= done_at + 2)) begin
            @(negedge Clk);
            cyc++;
            if (abort) abort = 1'b0;
            if (body_go) n_go++;
            if (f_inc)   n_inc++;
            if (f_rst)   n_rst++;
            if (f_wen) begin
                n_wen++;
                last_bus = int'(f_bus);
            end
            if (int'(f_wen) + int'(f_rst) + int'(f_inc) > 1) n_viol++;
            if (!f_wen && f_bus != 4'd0) n_viol++;
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = cyc;
            end
            start = s.spam && (body_go || f_inc || body_done);
            if (s.mode == 1 && !fired && body_done && n_go == s.abort_at) begin
                abort = 1'b1;
                fired = 1'b1;
                trig  = cyc;
            end
            if (s.mode == 2 && !fired) begin
                if (body_go) wd_cd = 255;
                else if (wd_cd > 0) begin
                    wd_cd--;
                    if (wd_cd == 0) begin
                        abort = 1'b1;
                        fired = 1'b1;
                        trig  = cyc;
                    end
                end
            end
        end
        start = 1'b0;
        abort = 1'b0;
        check({s.name, "_done_seen"}, int'(done_at >= 0), 1);
        check({s.name, "_done_pulses"}, n_done, 1);
        check({s.name, "_body_go"}, n_go, s.go);
        check({s.name, "_f_inc"}, n_inc, s.inc);
        check({s.name, "_f_rst"}, n_rst, s.rst);
        check({s.name, "_f_wen"}, n_wen, s.wen);
        if (s.wen > 0) check({s.name, "_f_bus"}, last_bus, s.bus);
        check({s.name, "_iter_cnt"}, int'(iter_cnt), s.iter);
        check({s.name, "_aborted"}, int'(aborted), int'(s.ab));
        check({s.name, "_timeout"}, int'(timeout), int'(s.to));
        check({s.name, "_strobe_rules"}, n_viol, 0);
        check({s.name, "_busy_after"}, int'(busy), 0);
        if (s.lat >= 0) check({s.name, "_latency"}, done_at - trig, s.lat);
    endtask

    initial begin
        int   k;
        int   n_done;
        scen_t s;

        //           name      limit  sv    resp  mode at spam  go  inc rst wen bus iter ab    to    lat
        tbl[0] = '{"cnt3",   5'd3,  4'd0, 1'b1, 0, 0, 1'b0, 3,  3,  1,  0,  0,  3, 1'b0, 1'b0,  26};
        tbl[1] = '{"zero",   5'd5,  4'd5, 1'b1, 0, 0, 1'b0, 0,  0,  0,  1,  5,  0, 1'b0, 1'b0,   5};
        tbl[2] = '{"abort2", 5'd4,  4'd0, 1'b1, 1, 2, 1'b0, 2,  1,  1,  0,  0,  1, 1'b1, 1'b0,   2};
        tbl[3] = '{"wdog",   5'd2,  4'd0, 1'b0, 0, 0, 1'b0, 1,  0,  1,  0,  0,  0, 1'b0, 1'b1, 262};
        tbl[4] = '{"wabort", 5'd2,  4'd0, 1'b0, 2, 0, 1'b0, 1,  0,  1,  0,  0,  0, 1'b1, 1'b0,   2};
        tbl[5] = '{"wrap16", 5'd16, 4'd0, 1'b1, 0, 0, 1'b0, 16, 16, 1,  0,  0,  0, 1'b0, 1'b0, 117};
        tbl[6] = '{"sv3",    5'd5,  4'd3, 1'b1, 0, 0, 1'b0, 2,  2,  0,  1,  3,  2, 1'b0, 1'b0,  19};
        tbl[7] = '{"spam",   5'd3,  4'd0, 1'b1, 0, 0, 1'b1, 3,  3,  1,  0,  0,  3, 1'b0, 1'b0,  26};

        RST = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        start_val = 4'd0;
        repeat (3) @(negedge Clk);
        check("reset_outs", all_outs(), 0);
        RST = 1'b0;
        @(negedge Clk);
        check("idle_outs", all_outs(), 0);

        // Abort in IDLE must not start or finish anything.
        abort = 1'b1;
        n_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            if (done || busy) n_done++;
        end
        abort = 1'b0;
        check("idle_abort_ignored", n_done, 0);

        for (int i = 0; i < 8; i++) begin
            run_scen(tbl[i]);
            repeat (2) @(negedge Clk);
        end

        // Kill a loop with RST in its first WAIT, then run a fresh loop.
        limit = 5'd3;
        resp_en = 1'b1;
        start_val = 4'd0;
        start = 1'b1;
        k = 0;
        @(negedge Clk);
        start = 1'b0;
        while (!body_go && k < 50) begin
            @(negedge Clk);
            k++;
        end
        check("kill_reach_wait", int'(body_go), 1);
        RST = 1'b1;
        n_done = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clk);
            check("kill_rst_outs", all_outs(), 0);
        end
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (done) n_done++;
        end
        check("kill_no_done", n_done, 0);
        s = '{"after_kill", 5'd3, 4'd1, 1'b1, 0, 0, 1'b0, 2, 2, 0, 1, 1, 2, 1'b0, 1'b0, 19};
        run_scen(s);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
